// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster timing constants and coordinate type
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster counters, registered sync/blank flags and frame counter
module vga_sync_gen import vga_timing_pkg::*; #(
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FP      = vga_timing_pkg::H_FP,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BP      = vga_timing_pkg::H_BP,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FP      = vga_timing_pkg::V_FP,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BP      = vga_timing_pkg::V_BP
) (
   input  logic       vga_clk,
   input  logic       Reset,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       sync,
   output coord_t     DrawX,
   output coord_t     DrawY,
   output logic       line_end,
   output logic       frame_end,
   output logic [7:0] frame_count
);

   localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
   localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
   localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   coord_t hc, vc;
   coord_t hc_nxt, vc_nxt;

   assign sync  = 1'b0;
   assign DrawX = hc;
   assign DrawY = vc;

   // next raster position: horizontal wraps every line, vertical wraps on the last line
   always_comb begin
      hc_nxt = hc + 10'd1;
      vc_nxt = vc;
      if (hc == H_LAST) begin
         hc_nxt = '0;
         if (vc == V_LAST) begin
            vc_nxt = '0;
         end else begin
            vc_nxt = vc + 10'd1;
         end
      end
   end

   // position counters
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         hc <= '0;
         vc <= '0;
      end else begin
         hc <= hc_nxt;
         vc <= vc_nxt;
      end
   end

   // flags decoded from the next position so they line up with DrawX/DrawY
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         hs        <= 1'b1;
         vs        <= 1'b1;
         blank     <= 1'b1;
         line_end  <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         hs        <= !((hc_nxt >= HS_START) && (hc_nxt < HS_END));
         vs        <= !((vc_nxt >= VS_START) && (vc_nxt < VS_END));
         blank     <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
         line_end  <= (hc_nxt == H_LAST);
         frame_end <= (hc_nxt == H_LAST) && (vc_nxt == V_LAST);
      end
   end

   // completed-frame counter, bumps on the wrap to (0,0)
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         frame_count <= '0;
      end else if ((hc == H_LAST) && (vc == V_LAST)) begin
         frame_count <= frame_count + 8'd1;
      end
   end

endmodule
